// File: rtl/dma_job_sched.sv
// Job scheduler in front of the dma engine: queues descriptors and issues each job's read then
// write command, overlapping the read of job k+1 with the write of job k; jobs retire in order.
module dma_job_sched #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned TOP_LEN_WIDTH  = 32,
    parameter int unsigned JOB_DEPTH      = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] job_src_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] job_dst_addr,
    input  logic [TOP_LEN_WIDTH-1:0]  job_len,
    input  logic                      halt,
    output logic                      read_start,
    output logic                      top_read_valid,
    output logic [AXI_ADDR_WIDTH-1:0] top_read_addr,
    output logic [TOP_LEN_WIDTH-1:0]  top_read_len,
    input  logic                      read_done,
    output logic                      write_start,
    output logic                      top_write_valid,
    output logic [AXI_ADDR_WIDTH-1:0] top_write_addr,
    output logic [TOP_LEN_WIDTH-1:0]  top_write_len,
    input  logic                      write_done,
    output logic                      job_done,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      jobs_completed,
    output logic                      err_zero_len
);
    localparam int unsigned PtrW = $clog2(JOB_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {RIdle, RBusy} r_state_e;
    typedef enum logic {WIdle, WBusy} w_state_e;

    r_state_e r_state_q, r_state_d;
    w_state_e w_state_q, w_state_d;

    logic [AXI_ADDR_WIDTH-1:0] fifo_src_q [JOB_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] fifo_src_d [JOB_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] fifo_dst_q [JOB_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] fifo_dst_d [JOB_DEPTH];
    logic [TOP_LEN_WIDTH-1:0]  fifo_len_q [JOB_DEPTH];
    logic [TOP_LEN_WIDTH-1:0]  fifo_len_d [JOB_DEPTH];
    logic [PtrW-1:0]           fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [CntW-1:0]           fifo_cnt_q, fifo_cnt_d;

    logic [AXI_ADDR_WIDTH-1:0] pq_dst_q [2];
    logic [AXI_ADDR_WIDTH-1:0] pq_dst_d [2];
    logic [TOP_LEN_WIDTH-1:0]  pq_len_q [2];
    logic [TOP_LEN_WIDTH-1:0]  pq_len_d [2];
    logic [1:0]                pq_done_q, pq_done_d;
    logic                      pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
    logic [1:0]                ahead_q, ahead_d;

    logic                      read_start_q, read_start_d, write_start_q, write_start_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [TOP_LEN_WIDTH-1:0]  rd_len_q, rd_len_d, wr_len_q, wr_len_d;
    logic                      job_done_q, job_done_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]      jobs_q, jobs_d;

    logic                      fifo_empty, push_acc, r_done_ev, w_pop, r_launch, w_launch;
    logic                      w_head, w_avail, pq_tail;
    logic [AXI_ADDR_WIDTH-1:0] l_src, l_dst;
    logic [TOP_LEN_WIDTH-1:0]  l_len;

    assign job_ready = (fifo_cnt_q < CntW'(JOB_DEPTH));

    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        push_acc   = job_valid && job_ready && (job_len != '0);
        r_done_ev  = (r_state_q == RBusy) && read_done;
        w_pop      = (w_state_q == WBusy) && write_done;

        // Launch decisions look one cycle ahead so the registered strobes meet the
        // push->read and read_done->write latencies; an empty FIFO bypasses the incoming job.
        r_launch = !halt && ((r_state_q == RIdle) || r_done_ev)
                   && ((ahead_q < 2'd2) || w_pop) && (!fifo_empty || push_acc);
        l_src    = fifo_empty ? job_src_addr : fifo_src_q[fifo_rd_q];
        l_dst    = fifo_empty ? job_dst_addr : fifo_dst_q[fifo_rd_q];
        l_len    = fifo_empty ? job_len      : fifo_len_q[fifo_rd_q];

        pq_tail  = ~pq_wr_q;
        w_head   = w_pop ? ~pq_rd_q : pq_rd_q;
        w_avail  = w_pop ? (ahead_q == 2'd2) : (ahead_q != 2'd0);
        w_launch = !halt && ((w_state_q == WIdle) || w_pop) && w_avail
                   && (pq_done_q[w_head] || (r_done_ev && (w_head == pq_tail)));

        fifo_src_d = fifo_src_q;
        fifo_dst_d = fifo_dst_q;
        fifo_len_d = fifo_len_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        if (push_acc && !(r_launch && fifo_empty)) begin
            fifo_src_d[fifo_wr_q] = job_src_addr;
            fifo_dst_d[fifo_wr_q] = job_dst_addr;
            fifo_len_d[fifo_wr_q] = job_len;
            fifo_wr_d             = fifo_wr_q + PtrW'(1);
        end
        if (r_launch && !fifo_empty) begin
            fifo_rd_d = fifo_rd_q + PtrW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CntW'(push_acc && !(r_launch && fifo_empty))
                     - CntW'(r_launch && !fifo_empty);

        pq_dst_d  = pq_dst_q;
        pq_len_d  = pq_len_q;
        pq_done_d = pq_done_q;
        pq_wr_d   = pq_wr_q;
        pq_rd_d   = pq_rd_q;
        if (r_done_ev) begin
            pq_done_d[pq_tail] = 1'b1;
        end
        if (r_launch) begin
            pq_dst_d[pq_wr_q]  = l_dst;
            pq_len_d[pq_wr_q]  = l_len;
            pq_done_d[pq_wr_q] = 1'b0;
            pq_wr_d            = ~pq_wr_q;
        end
        if (w_pop) begin
            pq_rd_d = ~pq_rd_q;
        end
        ahead_d = ahead_q + 2'(r_launch) - 2'(w_pop);

        r_state_d = r_state_q;
        if (r_launch) begin
            r_state_d = RBusy;
        end else if (r_done_ev) begin
            r_state_d = RIdle;
        end
        w_state_d = w_state_q;
        if (w_launch) begin
            w_state_d = WBusy;
        end else if (w_pop) begin
            w_state_d = WIdle;
        end

        read_start_d  = r_launch;
        rd_addr_d     = r_launch ? l_src : rd_addr_q;
        rd_len_d      = r_launch ? l_len : rd_len_q;
        write_start_d = w_launch;
        wr_addr_d     = w_launch ? pq_dst_q[w_head] : wr_addr_q;
        wr_len_d      = w_launch ? pq_len_q[w_head] : wr_len_q;
        job_done_d    = w_pop;
        jobs_d        = jobs_q + CNT_WIDTH'(w_pop);
        err_d         = err_q || (job_valid && job_ready && (job_len == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= RIdle;
            w_state_q     <= WIdle;
            fifo_src_q    <= '{default: '0};
            fifo_dst_q    <= '{default: '0};
            fifo_len_q    <= '{default: '0};
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_cnt_q    <= '0;
            pq_dst_q      <= '{default: '0};
            pq_len_q      <= '{default: '0};
            pq_done_q     <= '0;
            pq_rd_q       <= 1'b0;
            pq_wr_q       <= 1'b0;
            ahead_q       <= '0;
            read_start_q  <= 1'b0;
            rd_addr_q     <= '0;
            rd_len_q      <= '0;
            write_start_q <= 1'b0;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            job_done_q    <= 1'b0;
            jobs_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            r_state_q     <= r_state_d;
            w_state_q     <= w_state_d;
            fifo_src_q    <= fifo_src_d;
            fifo_dst_q    <= fifo_dst_d;
            fifo_len_q    <= fifo_len_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            pq_dst_q      <= pq_dst_d;
            pq_len_q      <= pq_len_d;
            pq_done_q     <= pq_done_d;
            pq_rd_q       <= pq_rd_d;
            pq_wr_q       <= pq_wr_d;
            ahead_q       <= ahead_d;
            read_start_q  <= read_start_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            write_start_q <= write_start_d;
            wr_addr_q     <= wr_addr_d;
            wr_len_q      <= wr_len_d;
            job_done_q    <= job_done_d;
            jobs_q        <= jobs_d;
            err_q         <= err_d;
        end
    end

    assign read_start      = read_start_q;
    assign top_read_valid  = read_start_q;
    assign top_read_addr   = rd_addr_q;
    assign top_read_len    = rd_len_q;
    assign write_start     = write_start_q;
    assign top_write_valid = write_start_q;
    assign top_write_addr  = wr_addr_q;
    assign top_write_len   = wr_len_q;
    assign job_done        = job_done_q;
    assign jobs_completed  = jobs_q;
    assign err_zero_len    = err_q;
    assign busy = (fifo_cnt_q != '0) || (ahead_q != '0) || (r_state_q != RIdle)
                  || (w_state_q != WIdle);

endmodule

// File: tb/tb_dma_job_sched.sv
// Bench for dma_job_sched: drives descriptors and DMA done pulses, scoreboards issued
// read/write commands against the pushed jobs and checks the cycle-level latencies.
module tb_dma_job_sched;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0, halt = 1'b0, read_done = 1'b0, write_done = 1'b0;
    logic [31:0] job_src_addr = '0, job_dst_addr = '0, job_len = '0;
    logic        job_ready, read_start, top_read_valid, write_start, top_write_valid;
    logic        job_done, busy, err_zero_len;
    logic [31:0] top_read_addr, top_read_len, top_write_addr, top_write_len;
    logic [15:0] jobs_completed;

    cmd_t exp_rd[$], exp_wr[$], obs_rd[$], obs_wr[$];
    int   n_cmp = 0, n_err = 0, obs_done = 0, exp_jobs = 0;

    always #5 clk = ~clk;

    dma_job_sched dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_src_addr(job_src_addr), .job_dst_addr(job_dst_addr), .job_len(job_len),
        .halt(halt), .read_start(read_start), .top_read_valid(top_read_valid),
        .top_read_addr(top_read_addr), .top_read_len(top_read_len), .read_done(read_done),
        .write_start(write_start), .top_write_valid(top_write_valid),
        .top_write_addr(top_write_addr), .top_write_len(top_write_len),
        .write_done(write_done), .job_done(job_done), .busy(busy),
        .jobs_completed(jobs_completed), .err_zero_len(err_zero_len)
    );

    // Collect every issued command and retirement as it appears.
    always @(negedge clk) begin
        if (read_start) obs_rd.push_back({top_read_addr, top_read_len});
        if (write_start) obs_wr.push_back({top_write_addr, top_write_len});
        if (job_done) obs_done++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        job_valid = 1'b1; job_src_addr = s; job_dst_addr = d; job_len = l;
        if (l != 0) begin
            exp_rd.push_back({s, l});
            exp_wr.push_back({d, l});
        end
        step();
        job_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_cmp++; if (job_ready !== 1'b1) begin n_err++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (jobs_completed !== 16'd0) begin n_err++; $display("FAIL reset_jobs: got %0d want 0", jobs_completed); end
        n_cmp++; if ({read_start, top_read_valid, write_start, top_write_valid, job_done, err_zero_len} !== 6'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b want 000000",
                {read_start, top_read_valid, write_start, top_write_valid, job_done, err_zero_len}); end
        n_cmp++; if ({top_read_addr, top_read_len, top_write_addr, top_write_len} !== 128'd0) begin
            n_err++; $display("FAIL reset_cmd_fields: got %h want 0",
                {top_read_addr, top_read_len, top_write_addr, top_write_len}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        cmd_t e, g;
        push(32'h1000, 32'h8000, 32'd64);                  // now T+1
        n_cmp++; if ({read_start, top_read_valid} !== 2'b11) begin n_err++; $display("FAIL single_read_start: got %b want 11", {read_start, top_read_valid}); end
        e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL single_rd_cmd: got %h want %h", g, e); end
        repeat (9) step();                                 // T+10
        n_cmp++; if ({top_read_addr, busy} !== {32'h1000, 1'b1}) begin n_err++; $display("FAIL single_hold: got %h/%b want 1000/1", top_read_addr, busy); end
        read_done = 1'b1; step(); read_done = 1'b0;        // T+11
        n_cmp++; if ({write_start, top_write_valid} !== 2'b11) begin n_err++; $display("FAIL single_write_start: got %b want 11", {write_start, top_write_valid}); end
        e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL single_wr_cmd: got %h want %h", g, e); end
        repeat (9) step();                                 // T+20
        write_done = 1'b1; step(); write_done = 1'b0;      // T+21
        exp_jobs++;
        n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL single_job_done: got %b want 1", job_done); end
        n_cmp++; if (jobs_completed !== 16'(exp_jobs)) begin n_err++; $display("FAIL single_jobs: got %0d want %0d", jobs_completed, exp_jobs); end
        step();
        n_cmp++; if ({job_done, busy} !== 2'b00) begin n_err++; $display("FAIL single_idle: got %b want 00", {job_done, busy}); end
    endtask

    task automatic test_overlap();
        cmd_t e, g;
        push(32'h100, 32'h900, 32'd8);
        n_cmp++; if (read_start !== 1'b1) begin n_err++; $display("FAIL ovl_rd0: got %b want 1", read_start); end
        push(32'h200, 32'hA00, 32'd16);
        push(32'h300, 32'hB00, 32'd4);
        e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_rd0_cmd: got %h want %h", g, e); end
        step();
        read_done = 1'b1; step(); read_done = 1'b0;
        n_cmp++; if ({read_start, write_start} !== 2'b11) begin n_err++; $display("FAIL ovl_rd1_wr0: got %b want 11", {read_start, write_start}); end
        e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_rd1_cmd: got %h want %h", g, e); end
        e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_wr0_cmd: got %h want %h", g, e); end
        read_done = 1'b1; step(); read_done = 1'b0;
        step();
        n_cmp++; if (obs_rd.size() != 0) begin n_err++; $display("FAIL ovl_ahead_block: got %0d reads want 0", obs_rd.size()); end
        write_done = 1'b1; step(); write_done = 1'b0;
        n_cmp++; if ({job_done, write_start, read_start} !== 3'b111) begin n_err++; $display("FAIL ovl_retire0: got %b want 111", {job_done, write_start, read_start}); end
        e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_rd2_cmd: got %h want %h", g, e); end
        e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_wr1_cmd: got %h want %h", g, e); end
        read_done = 1'b1; write_done = 1'b1; step(); read_done = 1'b0; write_done = 1'b0;
        n_cmp++; if ({job_done, write_start, read_start} !== 3'b110) begin n_err++; $display("FAIL ovl_both_done: got %b want 110", {job_done, write_start, read_start}); end
        e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL ovl_wr2_cmd: got %h want %h", g, e); end
        write_done = 1'b1; step(); write_done = 1'b0;
        exp_jobs += 3;
        n_cmp++; if ({job_done, busy, jobs_completed} !== {1'b1, 1'b0, 16'(exp_jobs)}) begin
            n_err++; $display("FAIL ovl_end: got %b/%b/%0d want 1/0/%0d", job_done, busy, jobs_completed, exp_jobs); end
        n_cmp++; if (obs_rd.size() + obs_wr.size() != 0) begin n_err++; $display("FAIL ovl_spurious: got %0d extra cmds want 0", obs_rd.size() + obs_wr.size()); end
    endtask

    task automatic test_full();
        cmd_t e, g;
        int done0 = obs_done;
        push(32'h2000, 32'hD000, 32'd1);
        read_done = 1'b1; step(); read_done = 1'b0;
        push(32'h2100, 32'hD100, 32'd2);
        read_done = 1'b1; step(); read_done = 1'b0;
        for (int i = 2; i < 6; i++) push(32'h2000 + 32'(i) * 32'h100, 32'hD000 + 32'(i) * 32'h100, 32'(i + 1));
        n_cmp++; if (job_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: got %b want 0", job_ready); end
        job_valid = 1'b1; job_src_addr = 32'h2600; job_dst_addr = 32'hD600; job_len = 32'd7;
        step();
        n_cmp++; if ({job_ready, read_start} !== 2'b00) begin n_err++; $display("FAIL full_hold: got %b want 00", {job_ready, read_start}); end
        write_done = 1'b1; step(); write_done = 1'b0; job_valid = 1'b0;
        n_cmp++; if ({job_ready, job_done, write_start, read_start} !== 4'b1111) begin
            n_err++; $display("FAIL full_pop: got %b want 1111", {job_ready, job_done, write_start, read_start}); end
        for (int i = 0; i < 40 && busy; i++) begin
            read_done = 1'b1; write_done = 1'b1; step();
        end
        read_done = 1'b0; write_done = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_drain: got busy %b want 0", busy); end
        while (exp_rd.size() != 0) begin
            e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL full_rd_order: got %h want %h", g, e); end
        end
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL full_wr_order: got %h want %h", g, e); end
        end
        n_cmp++; if (obs_rd.size() + obs_wr.size() != 0) begin n_err++; $display("FAIL full_extra_job: got %0d extra cmds want 0", obs_rd.size() + obs_wr.size()); end
        exp_jobs += 6;
        n_cmp++; if (obs_done - done0 != 6) begin n_err++; $display("FAIL full_done_count: got %0d want 6", obs_done - done0); end
        n_cmp++; if (jobs_completed !== 16'(exp_jobs)) begin n_err++; $display("FAIL full_jobs: got %0d want %0d", jobs_completed, exp_jobs); end
    endtask

    task automatic test_halt();
        cmd_t e, g;
        push(32'h4000, 32'hC000, 32'd32);
        e = exp_rd.pop_front(); g = (obs_rd.size() != 0) ? obs_rd.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL halt_rd_cmd: got %h want %h", g, e); end
        halt = 1'b1;
        read_done = 1'b1; step(); read_done = 1'b0;
        n_cmp++; if (write_start !== 1'b0) begin n_err++; $display("FAIL halt_no_write: got %b want 0", write_start); end
        repeat (3) step();
        n_cmp++; if ({obs_wr.size() == 0, busy} !== 2'b11) begin n_err++; $display("FAIL halt_held: got %0d writes busy %b want 0/1", obs_wr.size(), busy); end
        halt = 1'b0; step();
        n_cmp++; if (write_start !== 1'b1) begin n_err++; $display("FAIL halt_resume: got %b want 1", write_start); end
        e = exp_wr.pop_front(); g = (obs_wr.size() != 0) ? obs_wr.pop_front() : '0;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL halt_wr_cmd: got %h want %h", g, e); end
        write_done = 1'b1; step(); write_done = 1'b0;
        exp_jobs++;
        n_cmp++; if ({job_done, jobs_completed} !== {1'b1, 16'(exp_jobs)}) begin n_err++; $display("FAIL halt_done: got %b/%0d want 1/%0d", job_done, jobs_completed, exp_jobs); end
    endtask

    task automatic test_zero_len();
        push(32'h5000, 32'hE000, 32'd0);
        n_cmp++; if ({read_start, err_zero_len, busy} !== 3'b010) begin n_err++; $display("FAIL zero_push: got %b want 010", {read_start, err_zero_len, busy}); end
        step(); step();
        n_cmp++; if ({err_zero_len, busy, obs_rd.size() == 0} !== 3'b101) begin
            n_err++; $display("FAIL zero_sticky: got err %b busy %b reads %0d want 1/0/0", err_zero_len, busy, obs_rd.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(32'h6000 + 32'(i) * 32'h40, 32'hF000 + 32'(i) * 32'h40, 32'd5);
        read_done = 1'b1; step(); read_done = 1'b0;
        n_cmp++; if ({write_start, busy} !== 2'b11) begin n_err++; $display("FAIL rmid_wbusy: got %b want 11", {write_start, busy}); end
        rst_n = 1'b0; write_done = 1'b1; step(); rst_n = 1'b1; write_done = 1'b0;
        exp_jobs = 0;
        n_cmp++; if ({job_ready, busy, job_done, read_start, write_start, err_zero_len} !== 6'b100000) begin
            n_err++; $display("FAIL rmid_outputs: got %b want 100000", {job_ready, busy, job_done, read_start, write_start, err_zero_len}); end
        n_cmp++; if ({jobs_completed, top_write_addr, top_read_addr} !== 80'd0) begin
            n_err++; $display("FAIL rmid_values: got %0d/%h/%h want 0/0/0", jobs_completed, top_write_addr, top_read_addr); end
        write_done = 1'b1; step(); write_done = 1'b0;
        step();
        n_cmp++; if ({job_done, busy, jobs_completed} !== 18'd0) begin
            n_err++; $display("FAIL rmid_late_done: got %b/%b/%0d want 0/0/0", job_done, busy, jobs_completed); end
        exp_rd.delete(); exp_wr.delete(); obs_rd.delete(); obs_wr.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_full();
        test_halt();
        test_zero_len();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_job_sched.md
# dma_job_sched

Descriptor-driven scheduler that sits in front of the `dma` engine's top-decoder interface.
- Software or the top decoder pushes jobs (source address, destination address, beat count) into a small queue.
- The block issues each job's read phase, then its write phase, on the DMA's independent read and write command ports.
- The read of job k+1 overlaps the write of job k; jobs retire strictly in order.

## Interface
- AXI_ADDR_WIDTH, 32, byte address width of src/dst
- TOP_LEN_WIDTH, 32, job length width in AXI data beats
- JOB_DEPTH, 4, descriptor FIFO depth (power of 2, ≥2)
- CNT_WIDTH, 16, completed-job counter width
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- job_valid  in  1  descriptor push request
- job_ready  out  1  FIFO not full
- job_src_addr  in  AXI_ADDR_WIDTH  read base address
- job_dst_addr  in  AXI_ADDR_WIDTH  write base address
- job_len  in  TOP_LEN_WIDTH  beats; 0 is illegal
- halt  in  1  level; suppresses new launches
- read_start, top_read_valid  out  1  one-cycle read command strobe (both driven identically)
- top_read_addr  out  AXI_ADDR_WIDTH  read address, valid with strobe
- top_read_len  out  TOP_LEN_WIDTH  read length, valid with strobe
- read_done  in  1  one-cycle pulse from DMA, read phase complete
- write_start, top_write_valid  out  1  one-cycle write command strobe
- top_write_addr, top_write_len  out  AXI_ADDR_WIDTH / TOP_LEN_WIDTH  write command fields
- write_done  in  1  one-cycle pulse from DMA, write phase complete
- job_done  out  1  one-cycle pulse per retired job
- busy  out  1  any job queued or in flight
- jobs_completed  out  CNT_WIDTH  retired-job count, wraps
- err_zero_len  out  1  sticky; a job_len==0 push was discarded

## Operation
- **Push.** On job_valid && job_ready the descriptor is written into the FIFO.
  - If job_len==0, the descriptor is discarded and err_zero_len is set. It clears only on reset.
  - job_ready = (fifo_count < JOB_DEPTH).
- **Read FSM** (states R_IDLE, R_BUSY).
  - R_IDLE→R_BUSY when FIFO is non-empty, !halt, and ahead<2. In that cycle: pop the head, pulse read_start/top_read_valid, drive src/len, and push {dst, len} into the 2-entry pending queue.
  - R_BUSY→R_IDLE on read_done; that entry is marked read-complete.
- **Write FSM** (states W_IDLE, W_BUSY).
  - W_IDLE→W_BUSY when the pending-queue head is read-complete and !halt. In that cycle: pulse write_start/top_write_valid and drive dst/len.
  - W_BUSY→W_IDLE on write_done. In that cycle: pop the pending head, then pulse job_done next cycle and increment jobs_completed next cycle.
- **ahead** is the pending-queue occupancy (0..2). At most one read phase and one write phase are outstanding at any time.
- **halt** only blocks new launches. Commands already issued complete normally. Deasserting halt resumes launches.
- busy = fifo_count≠0 || ahead≠0 || either FSM not idle.
- Command address/len outputs hold their last launched value between strobes.

## Timing
- **Reset values.** Every output is 0 except job_ready=1. FSMs reset to idle. FIFO, pending queue and counters are cleared.
- **Reset mid-operation.** Reset asserted mid-job drops all queued and in-flight state. A read_done or write_done arriving in the reset cycle is ignored.
- **Latency.**
  - Push accepted at cycle T → read_start at T+1 at the earliest (empty FIFO, idle, !halt).
  - read_done at D → write_start at D+1 (write FSM idle).
  - write_done at E → job_done at E+1.
- **Simultaneous events.**
  - read_done and write_done in the same cycle are both honored.
  - Pop-for-write and push-from-read of the pending queue in the same cycle are both honored. Occupancy is unchanged.
  - Push and pop of the descriptor FIFO in the same cycle when full: the pop is honored. job_ready still reflects the pre-pop count, so the push is not accepted that cycle.
- **Ignored inputs.** read_done while R_IDLE and write_done while W_IDLE are ignored.
- **Wrap.** jobs_completed wraps from 2^CNT_WIDTH−1 to 0. FIFO pointers wrap modulo JOB_DEPTH.

## Test plan
- **Single job.** Push src=0x1000, dst=0x8000, len=64 at T → read_start at T+1 with addr 0x1000, len 64. Then read_done at T+10 → write_start at T+11 with addr 0x8000, len 64. Then write_done at T+20 → job_done at T+21 and jobs_completed=1.
- **Overlap and order.**
  - Push 3 jobs back-to-back → read of job1 starts the cycle after job0's read_done, while job0's write is still in progress.
  - Job2's read waits until ahead<2.
  - job_done pulses three times in order; dst addresses match their jobs.
- **Full FIFO.** Hold write_done low, push 4+2 jobs → job_ready=0 once the FIFO holds 4 entries with 2 jobs in flight. Extra pushes are not accepted; job_ready returns to 1 after the next pop.
- **Zero length.** Push len=0 → no read_start, err_zero_len=1 sticky, busy stays 0.
- **halt.** Assert halt during job0's read → job0's read finishes, no write_start while halt=1. Deassert halt → write_start next cycle.
- **Reset mid-operation.** Assert rst_n=0 during W_BUSY with 2 jobs queued → next cycle all outputs at reset values (job_ready=1, busy=0, jobs_completed=0). A late write_done produces no job_done.
